mac_layer_sequencer: RTL and testbench
======================================

Name: mac_layer_sequencer

Overview:
Upstream controller for a single MAC_Core that evaluates a fully connected layer one neuron at a time. It reads the input vector and per-neuron weights from two synchronous-read memories and streams operand pairs into MAC_Core. It drives the MAC's clear and output-enable, then captures each signed neuron result and emits it with its neuron index on a valid strobe. Results feed the activation/writeback stage downstream.

Parameters:
N, 8, operand and result width (matches MAC_Core N)
MAX_IN, 16, max inputs per neuron; power of two
MAX_NEU, 16, max neurons per layer; power of two
IAW, $clog2(MAX_IN), input-index / input-address width
NAW, $clog2(MAX_NEU), neuron-index width

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high
start  in  1  1-cycle request; ignored unless IDLE
n_inputs  in  IAW+1  inputs per neuron, 0..MAX_IN; latched at start
n_neurons  in  NAW+1  neurons in layer, 0..MAX_NEU; latched at start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  1-cycle pulse when the layer completes
in_addr  out  IAW  input-vector memory address
in_data  in  N  input-vector read data, valid 1 cycle after in_addr
w_addr  out  NAW+IAW  weight address = {neuron, k}
w_data  in  N  weight read data, valid 1 cycle after w_addr
mac_weight  out  N  to MAC_Core.weight
mac_in  out  N  to MAC_Core.in
mac_clear  out  1  to MAC_Core.reset
mac_oe  out  1  to MAC_Core.oe
mac_out  in  N  from MAC_Core.out
result_valid  out  1  1-cycle strobe
result_idx  out  NAW  neuron index of result_data
result_data  out  N  signed neuron sum, as produced by MAC_Core

Behaviour:
- Reset: state IDLE; busy, done, mac_clear, mac_oe, result_valid = 0; mac_weight, mac_in, in_addr, w_addr, result_idx, result_data = 0; counters = 0.
- MAC contract: MAC_Core adds mac_weight*mac_in on every clock with mac_clear low. The sequencer therefore holds mac_weight and mac_in at 0 in every cycle except the n_inputs valid-operand cycles.
- Operand path: the memory returns data 1 cycle after address issue. The sequencer registers it onto mac_weight/mac_in 1 cycle later, qualified by a delayed valid; otherwise it drives 0.
- FSM states: IDLE, CLEAR, ISSUE, DRAIN1, DRAIN2, READ, CAPTURE, DONE.
- IDLE: on start=1, latch n_inputs/n_neurons and set neuron=0. If either count is 0, go to DONE; otherwise go to CLEAR.
- CLEAR (1 cycle): mac_clear=1; k=0.
- ISSUE (n_inputs cycles): in_addr=k, w_addr={neuron,k}, k increments. Leave after k=n_inputs-1.
- DRAIN1, DRAIN2: no new addresses; the last operands propagate and accumulate.
- READ: mac_oe=1.
- CAPTURE: mac_oe=1; result_data<=mac_out, result_idx<=neuron; result_valid=1 for this cycle. If neuron=n_neurons-1, go to DONE; else neuron++ and go to CLEAR.
- DONE (1 cycle): done=1, busy=0 next; return to IDLE.
- Latency per neuron: n_inputs+5 cycles from CLEAR entry to CAPTURE inclusive. The first result_valid occurs n_inputs+5 cycles after the start edge. Layer total = n_neurons*(n_inputs+5)+1 cycles to the done pulse.
- busy covers every non-IDLE state.
- start while busy is ignored; config is never re-latched mid-layer.
- Counter limits:
  - n_inputs=MAX_IN: k reaches MAX_IN-1 without overflow; exit is by compare, never by wrap.
  - Same rule for neuron at MAX_NEU.
- Reset mid-operation overrides everything: next cycle all outputs are at reset values and no result_valid/done is emitted. The MAC accumulator is cleared by the next CLEAR.
- Arithmetic: the sequencer performs none. Signed interpretation and overflow belong to MAC_Core.

Decomposition:
- Package nn_pkg: FSM state enum; localparams for the DRAIN depth (2) and READ depth (2).
- One sub-module, mac_operand_pipe: the address→data→register path with delayed valid and zero insertion.

Test Plan:
- n_inputs=3, n_neurons=1, in=[2,2,2], w=[2,2,2]: mac_clear 1 cycle, then exactly 3 nonzero operand cycles; result_valid on cycle 8 after start with result_data=12, idx=0; done on cycle 9.
- n_neurons=2, weights row0=[2,2,2], row1=[2,-2,-2]: result 12 at idx0, then 0xFC (-4) at idx1 8 cycles later; mac_clear between them.
- n_inputs=0 or n_neurons=0: done pulses 1 cycle after start; no result_valid, mac_clear, or mac_oe activity.
- start re-pulsed during ISSUE with different counts: ignored; results match the original counts.
- reset asserted in DRAIN1: next cycle all outputs 0, FSM IDLE, no result_valid; a fresh start then yields the correct 12.
- n_inputs=MAX_IN=16, all w=1, in=1: result_data=16; w_addr spans {0,0}..{0,15} with no wrap.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types for the layer sequencer: FSM state encoding and pipeline depths.
package nn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ISSUE,
    ST_DRAIN1,
    ST_DRAIN2,
    ST_READ,
    ST_CAPTURE,
    ST_DONE
  } seq_state_e;

  // Cycles after the last ISSUE before the MAC holds the final sum, and
  // cycles spent with oe high before the sum is sampled.
  localparam int unsigned DRAIN_DEPTH = 2;
  localparam int unsigned READ_DEPTH  = 2;

endpackage

// File: rtl/mac_operand_pipe.sv
// Turns memory read data into MAC operands: the issue strobe is delayed to
// line up with read data, and operands are forced to zero when not valid.
module mac_operand_pipe #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         issue,
  input  logic [N-1:0] in_data,
  input  logic [N-1:0] w_data,
  output logic [N-1:0] mac_in,
  output logic [N-1:0] mac_weight
);

  logic         valid_q;
  logic [N-1:0] mac_in_q;
  logic [N-1:0] mac_weight_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      mac_in_q     <= '0;
      mac_weight_q <= '0;
    end else begin
      valid_q      <= issue;
      // Zero operands keep the always-accumulating MAC unchanged.
      mac_in_q     <= valid_q ? in_data : '0;
      mac_weight_q <= valid_q ? w_data  : '0;
    end
  end

  assign mac_in     = mac_in_q;
  assign mac_weight = mac_weight_q;

endmodule

// File: rtl/mac_layer_sequencer.sv
// Sequences one fully connected layer through a single MAC_Core, one neuron
// at a time, and emits each neuron sum with its index.
module mac_layer_sequencer
  import nn_pkg::*;
#(
  parameter int N       = 8,
  parameter int MAX_IN  = 16,
  parameter int MAX_NEU = 16,
  parameter int IAW     = $clog2(MAX_IN),
  parameter int NAW     = $clog2(MAX_NEU)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [IAW:0]       n_inputs,
  input  logic [NAW:0]       n_neurons,
  output logic               busy,
  output logic               done,
  output logic [IAW-1:0]     in_addr,
  input  logic [N-1:0]       in_data,
  output logic [NAW+IAW-1:0] w_addr,
  input  logic [N-1:0]       w_data,
  output logic [N-1:0]       mac_weight,
  output logic [N-1:0]       mac_in,
  output logic               mac_clear,
  output logic               mac_oe,
  input  logic [N-1:0]       mac_out,
  output logic               result_valid,
  output logic [NAW-1:0]     result_idx,
  output logic [N-1:0]       result_data,
  output logic [2:0]         dbg_state
);

  seq_state_e         state_q, state_d;
  logic [IAW-1:0]     k_q, k_d;
  logic [NAW-1:0]     neuron_q, neuron_d;
  logic [IAW:0]       n_in_q, n_in_d;
  logic [NAW:0]       n_neu_q, n_neu_d;
  logic               result_valid_q;
  logic [NAW-1:0]     result_idx_q;
  logic [N-1:0]       result_data_q;
  logic               done_q;
  logic               issue;
  logic               capture;
  logic               done_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      k_q            <= '0;
      neuron_q       <= '0;
      n_in_q         <= '0;
      n_neu_q        <= '0;
      result_valid_q <= 1'b0;
      result_idx_q   <= '0;
      result_data_q  <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      neuron_q       <= neuron_d;
      n_in_q         <= n_in_d;
      n_neu_q        <= n_neu_d;
      result_valid_q <= capture;
      done_q         <= done_set;
      if (capture) begin
        result_idx_q  <= neuron_q;
        result_data_q <= mac_out;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    neuron_d  = neuron_q;
    n_in_d    = n_in_q;
    n_neu_d   = n_neu_q;
    mac_clear = 1'b0;
    mac_oe    = 1'b0;
    issue     = 1'b0;
    capture   = 1'b0;
    done_set  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_in_d   = n_inputs;
          n_neu_d  = n_neurons;
          neuron_d = '0;
          state_d  = (n_inputs == '0 || n_neurons == '0) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        mac_clear = 1'b1;
        k_d       = '0;
        state_d   = ST_ISSUE;
      end
      ST_ISSUE: begin
        issue = 1'b1;
        // Exit by compare so k never wraps when n_inputs equals MAX_IN.
        if ({1'b0, k_q} == n_in_q - 1'b1) state_d = ST_DRAIN1;
        else                             k_d     = k_q + 1'b1;
      end
      ST_DRAIN1: state_d = ST_DRAIN2;
      ST_DRAIN2: state_d = ST_READ;
      ST_READ: begin
        mac_oe  = 1'b1;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        mac_oe  = 1'b1;
        capture = 1'b1;
        if ({1'b0, neuron_q} == n_neu_q - 1'b1) begin
          state_d = ST_DONE;
        end else begin
          neuron_d = neuron_q + 1'b1;
          state_d  = ST_CLEAR;
        end
      end
      ST_DONE: begin
        done_set = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mac_operand_pipe #(.N(N)) u_pipe (
    .clk        (clk),
    .reset      (reset),
    .issue      (issue),
    .in_data    (in_data),
    .w_data     (w_data),
    .mac_in     (mac_in),
    .mac_weight (mac_weight)
  );

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign in_addr      = issue ? k_q : '0;
  assign w_addr       = issue ? {neuron_q, k_q} : '0;
  assign result_valid = result_valid_q;
  assign result_idx   = result_idx_q;
  assign result_data  = result_data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Bench for mac_layer_sequencer with behavioural memories and a MAC_Core model;
// neuron sums are predicted from the memory contents into an expected queue.
module tb_mac_layer_sequencer;
  import nn_pkg::*;

  localparam int N       = 8;
  localparam int MAX_IN  = 16;
  localparam int MAX_NEU = 16;
  localparam int IAW     = 4;
  localparam int NAW     = 4;
  localparam int EW      = NAW + N;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [IAW:0]       n_inputs = '0;
  logic [NAW:0]       n_neurons = '0;
  logic               busy, done, mac_clear, mac_oe, result_valid;
  logic [IAW-1:0]     in_addr;
  logic [NAW+IAW-1:0] w_addr;
  logic [N-1:0]       in_data = '0;
  logic [N-1:0]       w_data = '0;
  logic [N-1:0]       mac_weight, mac_in, result_data;
  logic [N-1:0]       mac_out = '0;
  logic [N-1:0]       acc = '0;
  logic [NAW-1:0]     result_idx;
  logic [2:0]         dbg_state;

  logic [N-1:0] in_mem [MAX_IN];
  logic [N-1:0] w_mem  [MAX_NEU*MAX_IN];

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int n_cmp = 0;
  int n_bad = 0;
  int tb_cyc = 0;
  int start_cyc = 0;
  int clr_cnt, oe_cnt, op_cnt, rv_cnt, first_rv;
  logic [NAW+IAW-1:0] max_waddr;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  mac_layer_sequencer #(.N(N), .MAX_IN(MAX_IN), .MAX_NEU(MAX_NEU)) dut (
    .clk(clk), .reset(reset), .start(start), .n_inputs(n_inputs), .n_neurons(n_neurons),
    .busy(busy), .done(done), .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr),
    .w_data(w_data), .mac_weight(mac_weight), .mac_in(mac_in), .mac_clear(mac_clear),
    .mac_oe(mac_oe), .mac_out(mac_out), .result_valid(result_valid),
    .result_idx(result_idx), .result_data(result_data), .dbg_state(dbg_state)
  );

  // synchronous-read memories and MAC_Core model
  always @(posedge clk) begin
    in_data <= in_mem[in_addr];
    w_data  <= w_mem[w_addr];
    if (mac_clear) acc <= '0;
    else           acc <= acc + mac_weight * mac_in;
    if (mac_oe) mac_out <= acc;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (mac_clear) clr_cnt++;
    if (mac_oe) oe_cnt++;
    if (mac_weight != '0 || mac_in != '0) op_cnt++;
    if (w_addr > max_waddr) max_waddr = w_addr;
    if (result_valid) begin
      if (rv_cnt == 0) first_rv = tb_cyc - start_cyc;
      rv_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("rv_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("result", {20'd0, result_idx, result_data}, {20'd0, mon_e});
      end
    end
  end

  // driver tasks
  task automatic start_layer(input int nin, input int nneu);
    logic [N-1:0] sum;
    for (int j = 0; j < nneu && nin > 0; j++) begin
      sum = '0;
      for (int k = 0; k < nin; k++) sum = sum + in_mem[k] * w_mem[j*MAX_IN + k];
      exp_q.push_back({NAW'(j), sum});
    end
    @(negedge clk);
    clr_cnt = 0; oe_cnt = 0; op_cnt = 0; rv_cnt = 0; first_rv = -1; max_waddr = '0;
    n_inputs  = (IAW+1)'(nin);
    n_neurons = (NAW+1)'(nneu);
    start     = 1'b1;
    start_cyc = tb_cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    int guard = 0;
    while (done !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check_eq("done_timeout", 32'd0, 32'd1);
    cyc = tb_cyc - start_cyc;
  endtask

  task automatic run_layer(input int nin, input int nneu, input bit check_ops);
    int cyc;
    bit zero;
    zero = (nin == 0 || nneu == 0);
    start_layer(nin, nneu);
    check_eq("busy_after_start", 32'(busy), 32'd1);
    wait_done(cyc);
    check_eq("done_cycle", cyc, zero ? 1 : nneu * (nin + 5) + 1);
    check_eq("rv_count", rv_cnt, zero ? 0 : nneu);
    check_eq("clear_count", clr_cnt, zero ? 0 : nneu);
    check_eq("oe_count", oe_cnt, zero ? 0 : 2 * nneu);
    if (check_ops) check_eq("operand_cycles", op_cnt, zero ? 0 : nin * nneu);
    if (!zero) check_eq("first_rv_latency", first_rv, nin + 5);
    check_eq("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    check_eq("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < MAX_IN; i++) in_mem[i] = N'($urandom_range(0, 255));
    for (int i = 0; i < MAX_NEU*MAX_IN; i++) w_mem[i] = N'($urandom_range(0, 255));
  endtask

  task automatic fill_plan();
    fill_random();
    for (int k = 0; k < 3; k++) begin
      in_mem[k]         = 8'd2;
      w_mem[k]          = 8'd2;
      w_mem[MAX_IN + k] = (k == 0) ? 8'd2 : 8'hFE;
    end
  endtask

  initial begin
    int cyc;
    fill_plan();
    repeat (3) @(negedge clk);
    check_eq("reset_ctrl", {27'd0, busy, done, mac_clear, mac_oe, result_valid}, 32'd0);
    check_eq("reset_data", {mac_weight, mac_in, result_data, result_idx, in_addr}, 32'd0);
    check_eq("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;

    run_layer(3, 1, 1'b1);
    run_layer(3, 2, 1'b1);
    run_layer(0, 2, 1'b1);
    run_layer(2, 0, 1'b1);

    // start re-pulsed mid-ISSUE with different counts is ignored
    start_layer(3, 2);
    repeat (2) @(negedge clk);
    check_eq("state_issue", 32'(dbg_state), 32'(ST_ISSUE));
    n_inputs = 5; n_neurons = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check_eq("repulse_done_cycle", cyc, 17);
    check_eq("repulse_rv_count", rv_cnt, 2);
    @(negedge clk);

    // reset in DRAIN1 aborts the layer silently
    start_layer(3, 1);
    repeat (4) @(negedge clk);
    check_eq("state_drain1", 32'(dbg_state), 32'(ST_DRAIN1));
    reset = 1'b1;
    @(negedge clk);
    check_eq("midreset_ctrl", {27'd0, busy, done, mac_clear, mac_oe, result_valid}, 32'd0);
    check_eq("midreset_data", {mac_weight, mac_in, result_data, result_idx, in_addr}, 32'd0);
    check_eq("midreset_waddr", 32'(w_addr), 32'd0);
    check_eq("midreset_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("midreset_no_rv", rv_cnt, 0);
    run_layer(3, 1, 1'b1);

    // full-depth input vector
    for (int k = 0; k < MAX_IN; k++) begin
      in_mem[k] = 8'd1;
      w_mem[k]  = 8'd1;
    end
    run_layer(16, 1, 1'b1);
    check_eq("max_waddr", 32'(max_waddr), 32'd15);

    // randomised layers
    fill_random();
    run_layer(5, 3, 1'b0);
    run_layer(1, 1, 1'b0);
    fill_random();
    run_layer(16, 16, 1'b0);
    run_layer($urandom_range(1, 16), $urandom_range(1, 16), 1'b0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
